// File: rtl/param_serializer.sv
// Purpose : parametrised parallel-to-serial converter for the UART TX path (width, bit order, idle level, frame length).
// Latency : 1 cycle from accepted load to first bit on ser_out; one bit advanced per Enable cycle.
// Backpressure: Load_Ready gates loads; a Data_Valid seen while not ready is dropped and flagged by an overrun pulse.
//
// Ports:
//   CLK, RST      clock (rising edge) and asynchronous active-low reset
//   DATA          parallel word, captured together with Frame_Len on an accepted load
//   Frame_Len     bits to send; 0 or >WIDTH means WIDTH
//   Data_Valid    load request; Load_Ready (combinational) says it is accepted this cycle
//   Enable        shift strobe (baud tick)
//   ser_out       registered serial bit, IDLE_LEVEL when idle
//   busy          registered frame-in-progress flag
//   ser_done      one-cycle pulse after the last bit of a frame is consumed
//   overrun       one-cycle pulse after a load request was dropped
module param_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   LEN_W      = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic [LEN_W-1:0] Frame_Len,
  input  logic             Data_Valid,
  output logic             Load_Ready,
  input  logic             Enable,
  output logic             ser_out,
  output logic             busy,
  output logic             ser_done,
  output logic             overrun
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ser_out_q, ser_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  logic [LEN_W-1:0] eff_len;
  logic             last;
  logic             load;
  logic             first_bit;

  always_comb begin
    eff_len = ((Frame_Len == '0) || (Frame_Len > FULL_LEN)) ? FULL_LEN : Frame_Len;
    // len_q is never 0 while shifting, so len_q-1 is a valid bit index
    last       = (cnt_q == (len_q - LEN_W'(1)));
    Load_Ready = (state_q == ST_IDLE) | ((state_q == ST_SHIFT) & Enable & last);
    load       = Data_Valid & Load_Ready;
    first_bit  = MSB_FIRST ? DATA[WIDTH-1] : DATA[0];
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ser_out_d = ser_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovr_d     = Data_Valid & ~Load_Ready;

    if (load) begin
      // A load in SHIFT can only happen on the last-bit Enable cycle, so that
      // frame completes on this same edge with no idle gap.
      done_d    = (state_q == ST_SHIFT);
      state_d   = ST_SHIFT;
      shreg_d   = DATA;
      cnt_d     = '0;
      len_d     = eff_len;
      busy_d    = 1'b1;
      ser_out_d = first_bit;
    end else if ((state_q == ST_SHIFT) && Enable) begin
      if (last) begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        ser_out_d = IDLE_LEVEL;
      end else begin
        cnt_d = cnt_q + LEN_W'(1);
        // ser_out already shows the current output-end bit, so the next bit
        // is the neighbour one position in from that end.
        if (MSB_FIRST) begin
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          ser_out_d = shreg_q[WIDTH-2];
        end else begin
          shreg_d   = {1'b0, shreg_q[WIDTH-1:1]};
          ser_out_d = shreg_q[1];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ser_out_q <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ser_out  = ser_out_q;
  assign busy     = busy_q;
  assign ser_done = done_q;
  assign overrun  = ovr_q;

endmodule
